// File: rtl/parking_meter_param.sv
`default_nettype none
// ============================================================================
// Module   : parking_meter_param
// Purpose  : Coin-fed parking meter. Tracks remaining seconds (0..MAX_TIME),
//            counts down once per second, loads two presets, and drives a
//            multiplexed 4-digit active-low 7-segment display that blinks
//            when time is low or expired.
// Revision : 1.0 - initial release
// ============================================================================
module parking_meter_param #(
  parameter int                      CLK_PER_SEC = 100,
  parameter int                      SCAN_DIV    = 1,
  parameter int                      NUM_COINS   = 4,
  parameter logic [14*NUM_COINS-1:0] COIN_VAL    = {14'd300, 14'd180, 14'd120, 14'd60},
  parameter int                      MAX_TIME    = 9999,
  parameter int                      LOW_THRESH  = 180,
  parameter int                      PRESET1     = 15,
  parameter int                      PRESET2     = 150
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_COINS-1:0] add,
  input  logic                 rst1,
  input  logic                 rst2,
  output logic                 a1,
  output logic                 a2,
  output logic                 a3,
  output logic                 a4,
  output logic [6:0]           led_seg,
  output logic [3:0]           val1,
  output logic [3:0]           val2,
  output logic [3:0]           val3,
  output logic [3:0]           val4,
  output logic                 expired
);

  // Widths: credit needs headroom for every coin firing at once.
  localparam int PW     = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam int SW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CRED_W = 15 + $clog2(NUM_COINS + 1);

  logic [13:0]          r_cnt;
  logic [PW-1:0]        r_pre;
  logic [SW-1:0]        r_sdiv;
  logic [1:0]           r_digit;
  logic [NUM_COINS-1:0] r_add_q;
  logic                 r_rst1_q;
  logic                 r_rst2_q;

  logic [NUM_COINS-1:0] w_add_edge;
  logic                 w_rst1_edge;
  logic                 w_rst2_edge;
  logic                 w_tick;
  logic                 w_dec;
  logic [CRED_W-1:0]    w_credit;
  logic [CRED_W-1:0]    w_sum;
  logic [15:0]          w_bcd;
  logic [3:0]           w_digit;
  logic [3:0]           w_anode;
  logic                 w_show;

  assign w_add_edge  = add & ~r_add_q;
  assign w_rst1_edge = rst1 & ~r_rst1_q;
  assign w_rst2_edge = rst2 & ~r_rst2_q;
  assign w_tick      = (r_pre == PW'(CLK_PER_SEC - 1));
  assign w_dec       = w_tick && (r_cnt != 14'd0);

  // Sum the value of every coin whose insert level rose this cycle.
  always_comb begin
    w_credit = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (w_add_edge[i]) begin
        w_credit = w_credit + CRED_W'(COIN_VAL[14*i +: 14]);
      end
    end
  end

  assign w_sum = CRED_W'(r_cnt) - CRED_W'(w_dec) + w_credit;

  // Input edge registers and the one-second prescaler (restarted by presets only).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_add_q  <= '0;
      r_rst1_q <= 1'b0;
      r_rst2_q <= 1'b0;
      r_pre    <= '0;
    end else begin
      r_add_q  <= add;
      r_rst1_q <= rst1;
      r_rst2_q <= rst2;
      if (w_rst1_edge || w_rst2_edge || w_tick) begin
        r_pre <= '0;
      end else begin
        r_pre <= r_pre + PW'(1);
      end
    end
  end

  // Remaining-time register: reset, then presets, then countdown plus credit with saturation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 14'd0;
    end else if (w_rst1_edge) begin
      r_cnt <= 14'(PRESET1);
    end else if (w_rst2_edge) begin
      r_cnt <= 14'(PRESET2);
    end else if (w_sum > CRED_W'(MAX_TIME)) begin
      r_cnt <= 14'(MAX_TIME);
    end else begin
      r_cnt <= w_sum[13:0];
    end
  end

  // Digit scan: step to the next anode every SCAN_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sdiv  <= '0;
      r_digit <= 2'd0;
    end else if (r_sdiv == SW'(SCAN_DIV - 1)) begin
      r_sdiv  <= '0;
      r_digit <= r_digit + 2'd1;
    end else begin
      r_sdiv  <= r_sdiv + SW'(1);
    end
  end

  // Binary to BCD by shift-and-add-3; cnt never exceeds four decimal digits.
  always_comb begin
    w_bcd = 16'd0;
    for (int i = 13; i >= 0; i--) begin
      for (int j = 0; j < 4; j++) begin
        if (w_bcd[4*j +: 4] >= 4'd5) begin
          w_bcd[4*j +: 4] = w_bcd[4*j +: 4] + 4'd3;
        end
      end
      w_bcd = {w_bcd[14:0], r_cnt[i]};
    end
  end

  // Pick the digit and anode for the current scan slot (a1 = thousands).
  always_comb begin
    w_digit = w_bcd[15:12];
    w_anode = 4'b0111;
    case (r_digit)
      2'd0: begin w_digit = w_bcd[15:12]; w_anode = 4'b0111; end
      2'd1: begin w_digit = w_bcd[11:8];  w_anode = 4'b1011; end
      2'd2: begin w_digit = w_bcd[7:4];   w_anode = 4'b1101; end
      default: begin w_digit = w_bcd[3:0]; w_anode = 4'b1110; end
    endcase
  end

  // Blink policy: steady when plenty of time, 2 s blink when low, 1 s blink when expired.
  always_comb begin
    if (r_cnt >= 14'(LOW_THRESH)) begin
      w_show = 1'b1;
    end else if (r_cnt != 14'd0) begin
      w_show = ~r_cnt[0];
    end else begin
      w_show = (r_pre < PW'(CLK_PER_SEC / 2));
    end
  end

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'b1000000;
      4'd1:    f_seg = 7'b1111001;
      4'd2:    f_seg = 7'b0100100;
      4'd3:    f_seg = 7'b0110000;
      4'd4:    f_seg = 7'b0011001;
      4'd5:    f_seg = 7'b0010010;
      4'd6:    f_seg = 7'b0000010;
      4'd7:    f_seg = 7'b1111000;
      4'd8:    f_seg = 7'b0000000;
      4'd9:    f_seg = 7'b0010000;
      default: f_seg = 7'b1111111;
    endcase
  endfunction

  assign {a1, a2, a3, a4} = w_show ? w_anode : 4'b1111;
  assign led_seg          = w_show ? f_seg(w_digit) : 7'b1111111;
  assign val1             = w_bcd[15:12];
  assign val2             = w_bcd[11:8];
  assign val3             = w_bcd[7:4];
  assign val4             = w_bcd[3:0];
  assign expired          = (r_cnt == 14'd0);

endmodule
`default_nettype wire

// File: tb/tb_parking_meter_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_parking_meter_param
// Purpose  : Directed self-checking bench for parking_meter_param (defaults).
// Revision : 1.0 - initial release
// ============================================================================
module tb_parking_meter_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] add = 4'b0000;
  logic       rst1 = 1'b0;
  logic       rst2 = 1'b0;
  logic       a1, a2, a3, a4, expired;
  logic [6:0] led_seg;
  logic [3:0] val1, val2, val3, val4;

  int checks = 0;
  int errors = 0;

  logic [15:0] vals;
  logic [10:0] disp;
  assign vals = {val1, val2, val3, val4};
  assign disp = {a1, a2, a3, a4, led_seg};

  localparam logic [10:0] BLANK = {4'b1111, 7'b1111111};

  parking_meter_param dut (
    .clk(clk), .rst(rst), .add(add), .rst1(rst1), .rst2(rst2),
    .a1(a1), .a2(a2), .a3(a3), .a4(a4), .led_seg(led_seg),
    .val1(val1), .val2(val2), .val3(val3), .val4(val4), .expired(expired)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; add = 4'b0000; rst1 = 1'b0; rst2 = 1'b0;
    repeat (10) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0]  an;
    logic [10:0] exp_d;
    do_reset();
    checks++; if (vals !== 16'h0000) begin errors++; $display("FAIL reset_val got=%h exp=%h", vals, 16'h0000); end
    checks++; if (expired !== 1'b1) begin errors++; $display("FAIL reset_expired got=%b exp=1", expired); end
    checks++; if (disp !== {4'b0111, 7'b1000000}) begin errors++; $display("FAIL reset_disp got=%b exp=%b", disp, {4'b0111, 7'b1000000}); end
    for (int i = 0; i < 100; i++) begin
      an = 4'b1111;
      an[3 - (i % 4)] = 1'b0;
      exp_d = (i < 50) ? {an, 7'b1000000} : BLANK;
      checks++; if (disp !== exp_d) begin errors++; $display("FAIL zero_blink[%0d] got=%b exp=%b", i, disp, exp_d); end
      step();
    end
  endtask

  task automatic test_coin_countdown();
    do_reset();
    add = 4'b0001; step(); add = 4'b0000;                          // t=1
    checks++; if (vals !== 16'h0060) begin errors++; $display("FAIL coin60_val got=%h exp=%h", vals, 16'h0060); end
    checks++; if (expired !== 1'b0) begin errors++; $display("FAIL coin60_expired got=%b exp=0", expired); end
    checks++; if (disp !== {4'b1011, 7'b1000000}) begin errors++; $display("FAIL coin60_disp got=%b exp=%b", disp, {4'b1011, 7'b1000000}); end
    repeat (99) step();                                            // t=100: first tick
    checks++; if (vals !== 16'h0059) begin errors++; $display("FAIL tick59_val got=%h exp=%h", vals, 16'h0059); end
    checks++; if (disp !== BLANK) begin errors++; $display("FAIL tick59_blank got=%b exp=%b", disp, BLANK); end
    repeat (5899) step();                                          // t=5999
    checks++; if (vals !== 16'h0001) begin errors++; $display("FAIL cnt1_val got=%h exp=%h", vals, 16'h0001); end
    step();                                                        // t=6000
    checks++; if (vals !== 16'h0000) begin errors++; $display("FAIL cnt0_val got=%h exp=%h", vals, 16'h0000); end
    checks++; if (expired !== 1'b1) begin errors++; $display("FAIL cnt0_expired got=%b exp=1", expired); end
    checks++; if (disp !== {4'b0111, 7'b1000000}) begin errors++; $display("FAIL cnt0_disp got=%b exp=%b", disp, {4'b0111, 7'b1000000}); end
    repeat (50) step();                                            // t=6050: second half of second
    checks++; if (disp !== BLANK) begin errors++; $display("FAIL cnt0_blank got=%b exp=%b", disp, BLANK); end
    repeat (50) step();                                            // t=6100: tick at zero
    checks++; if (vals !== 16'h0000) begin errors++; $display("FAIL nowrap_val got=%h exp=%h", vals, 16'h0000); end
    checks++; if (expired !== 1'b1) begin errors++; $display("FAIL nowrap_expired got=%b exp=1", expired); end
  endtask

  task automatic test_coin_pair_and_hold();
    do_reset();
    add = 4'b0011; step(); add = 4'b0000;                          // t=1
    checks++; if (vals !== 16'h0180) begin errors++; $display("FAIL pair_val got=%h exp=%h", vals, 16'h0180); end
    checks++; if (disp !== {4'b1011, 7'b1111001}) begin errors++; $display("FAIL pair_disp got=%b exp=%b", disp, {4'b1011, 7'b1111001}); end
    add = 4'b0100; step();                                         // t=2
    checks++; if (vals !== 16'h0360) begin errors++; $display("FAIL hold_first_val got=%h exp=%h", vals, 16'h0360); end
    repeat (97) step();                                            // t=99
    checks++; if (vals !== 16'h0360) begin errors++; $display("FAIL hold_mid_val got=%h exp=%h", vals, 16'h0360); end
    checks++; if (disp !== {4'b1110, 7'b1000000}) begin errors++; $display("FAIL hold_mid_disp got=%b exp=%b", disp, {4'b1110, 7'b1000000}); end
    repeat (402) step();                                           // t=501, 5 ticks elapsed
    checks++; if (vals !== 16'h0355) begin errors++; $display("FAIL hold_end_val got=%h exp=%h", vals, 16'h0355); end
    checks++; if (disp !== {4'b1011, 7'b0110000}) begin errors++; $display("FAIL hold_end_disp got=%b exp=%b", disp, {4'b1011, 7'b0110000}); end
    add = 4'b0000;
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k < 35; k++) begin
      add = 4'b1000; step(); add = 4'b0000; step();
    end                                                            // t=70
    checks++; if (vals !== 16'h9999) begin errors++; $display("FAIL sat_val got=%h exp=%h", vals, 16'h9999); end
    repeat (29) step();                                            // t=99
    checks++; if (vals !== 16'h9999) begin errors++; $display("FAIL sat_hold_val got=%h exp=%h", vals, 16'h9999); end
    checks++; if (disp !== {4'b1110, 7'b0010000}) begin errors++; $display("FAIL sat_disp got=%b exp=%b", disp, {4'b1110, 7'b0010000}); end
    step();                                                        // t=100
    checks++; if (vals !== 16'h9998) begin errors++; $display("FAIL sat_tick_val got=%h exp=%h", vals, 16'h9998); end
    checks++; if (disp !== {4'b0111, 7'b0010000}) begin errors++; $display("FAIL sat_tick_disp got=%b exp=%b", disp, {4'b0111, 7'b0010000}); end
  endtask

  task automatic test_presets();
    do_reset();
    add = 4'b1000; step(); add = 4'b0000;                          // t=1: 300
    repeat (999) step();                                           // t=1000: 10 ticks
    checks++; if (vals !== 16'h0290) begin errors++; $display("FAIL pre_setup_val got=%h exp=%h", vals, 16'h0290); end
    rst1 = 1'b1; step(); rst1 = 1'b0;                              // t=1001
    checks++; if (vals !== 16'h0015) begin errors++; $display("FAIL rst1_val got=%h exp=%h", vals, 16'h0015); end
    checks++; if (disp !== BLANK) begin errors++; $display("FAIL rst1_odd_blank got=%b exp=%b", disp, BLANK); end
    repeat (99) step();                                            // t=1100
    checks++; if (vals !== 16'h0015) begin errors++; $display("FAIL rst1_phase_val got=%h exp=%h", vals, 16'h0015); end
    step();                                                        // t=1101
    checks++; if (vals !== 16'h0014) begin errors++; $display("FAIL rst1_tick_val got=%h exp=%h", vals, 16'h0014); end
    checks++; if (disp !== {4'b1011, 7'b1000000}) begin errors++; $display("FAIL rst1_even_disp got=%b exp=%b", disp, {4'b1011, 7'b1000000}); end
    rst1 = 1'b1; rst2 = 1'b1; step(); rst1 = 1'b0; rst2 = 1'b0;    // t=1102
    checks++; if (vals !== 16'h0015) begin errors++; $display("FAIL both_val got=%h exp=%h", vals, 16'h0015); end
    step();                                                        // t=1103
    rst2 = 1'b1; step(); rst2 = 1'b0;                              // t=1104
    checks++; if (vals !== 16'h0150) begin errors++; $display("FAIL rst2_val got=%h exp=%h", vals, 16'h0150); end
    checks++; if (disp !== {4'b0111, 7'b1000000}) begin errors++; $display("FAIL rst2_even_disp got=%b exp=%b", disp, {4'b0111, 7'b1000000}); end
    repeat (100) step();                                           // t=1204
    checks++; if (vals !== 16'h0149) begin errors++; $display("FAIL rst2_tick_val got=%h exp=%h", vals, 16'h0149); end
    checks++; if (disp !== BLANK) begin errors++; $display("FAIL rst2_odd_blank got=%b exp=%b", disp, BLANK); end
  endtask

  task automatic test_tick_coincident();
    do_reset();
    for (int k = 0; k < 35; k++) begin
      add = 4'b1000; step(); add = 4'b0000; step();
    end                                                            // t=70
    repeat (929) step();                                           // t=999: 9 ticks
    checks++; if (vals !== 16'h9990) begin errors++; $display("FAIL coin_tick_setup got=%h exp=%h", vals, 16'h9990); end
    add = 4'b0001; step(); add = 4'b0000;                          // t=1000
    checks++; if (vals !== 16'h9999) begin errors++; $display("FAIL coin_tick_sat got=%h exp=%h", vals, 16'h9999); end
    do_reset();
    repeat (99) step();                                            // t=99
    add = 4'b0001; step(); add = 4'b0000;                          // t=100
    checks++; if (vals !== 16'h0060) begin errors++; $display("FAIL coin_tick_zero got=%h exp=%h", vals, 16'h0060); end
    checks++; if (expired !== 1'b0) begin errors++; $display("FAIL coin_tick_zero_exp got=%b exp=0", expired); end
  endtask

  task automatic test_reset_override();
    // cnt is 60 from the previous scenario
    rst = 1'b1; add = 4'b0010; rst1 = 1'b1; step(); rst1 = 1'b0;
    checks++; if (vals !== 16'h0000) begin errors++; $display("FAIL ovr_val got=%h exp=%h", vals, 16'h0000); end
    checks++; if (expired !== 1'b1) begin errors++; $display("FAIL ovr_expired got=%b exp=1", expired); end
    checks++; if (disp !== {4'b0111, 7'b1000000}) begin errors++; $display("FAIL ovr_disp got=%b exp=%b", disp, {4'b0111, 7'b1000000}); end
    rst = 1'b0; step();
    checks++; if (vals !== 16'h0120) begin errors++; $display("FAIL held_edge_val got=%h exp=%h", vals, 16'h0120); end
    step();
    checks++; if (vals !== 16'h0120) begin errors++; $display("FAIL held_noretrig_val got=%h exp=%h", vals, 16'h0120); end
    add = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_coin_countdown();
    test_coin_pair_and_hold();
    test_saturate();
    test_presets();
    test_tick_coincident();
    test_reset_override();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/parking_meter_param.md
PARKING_METER_PARAM -- requirements
Module: parking_meter_param

Interface
REQ-001 The block SHALL have parameter CLK_PER_SEC, default 100, clock cycles per one-second tick.
REQ-002 The block SHALL have parameter SCAN_DIV, default 1, clock cycles per display digit slot.
REQ-003 The block SHALL have parameter NUM_COINS, default 4, number of coin inputs.
REQ-004 The block SHALL have parameter COIN_VAL, default {14'd300,14'd180,14'd120,14'd60}, packed 14-bit credit per coin; add[i] uses slice i.
REQ-005 The block SHALL have parameters MAX_TIME 9999, LOW_THRESH 180, PRESET1 15 and PRESET2 150, all in seconds.
REQ-006 Port clk, input, 1 bit: the single clock.
REQ-007 Port rst, input, 1 bit: synchronous active-high reset.
REQ-008 Port add, input, NUM_COINS bits: coin insert levels.
REQ-009 Port rst1, input, 1 bit: load PRESET1.
REQ-010 Port rst2, input, 1 bit: load PRESET2.
REQ-011 Ports a1, a2, a3, a4, outputs, 1 bit each: active-low digit anodes, a1 = thousands, a4 = ones.
REQ-012 Port led_seg, output, 7 bits: active-low segments {g,f,e,d,c,b,a} for the active digit.
REQ-013 Ports val1, val2, val3, val4, outputs, 4 bits each: BCD thousands, hundreds, tens and ones of the remaining time.
REQ-014 Port expired, output, 1 bit: high while the remaining time is 0.

Function
REQ-015 The block SHALL hold remaining time in a 14-bit register cnt with range 0..MAX_TIME.
REQ-016 Each add[i], rst1 and rst2 SHALL be registered once and acted on at its rising edge only; a held level SHALL NOT re-trigger.
REQ-017 Credit SHALL be the sum of COIN_VAL over all add bits with a rising edge in the same cycle, computed in at least 17 bits.
REQ-018 The prescaler SHALL count 0..CLK_PER_SEC-1 and wrap, asserting tick for one cycle at CLK_PER_SEC-1.
REQ-019 Next cnt SHALL follow this priority: (1) rst; (2) rst1 or rst2 edge loads its preset and clears the prescaler, rst1 winning if both; (3) otherwise min(cnt - (tick && cnt>0) + credit, MAX_TIME).
REQ-020 At cnt = 0 a tick SHALL leave cnt at 0, with no wrap.
REQ-021 A coin edge SHALL NOT reset or alter the prescaler phase.
REQ-022 val1..val4 SHALL be the combinational BCD of the current cnt, independent of blanking.
REQ-023 expired SHALL equal (cnt == 0).
REQ-024 The scan counter SHALL advance one digit every SCAN_DIV cycles in the order a1, a2, a3, a4, a1, with exactly one anode low when the display is unblanked.
REQ-025 led_seg SHALL encode the BCD digit of the active anode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-026 When cnt >= LOW_THRESH the display SHALL be always shown.
REQ-027 When 0 < cnt < LOW_THRESH the display SHALL be shown if cnt is even and blanked if cnt is odd, giving a 2 s period.
REQ-028 When cnt = 0 the display SHALL show 0000 while prescaler < CLK_PER_SEC/2 and be blanked otherwise, giving a 1 s period.
REQ-029 Blanking SHALL drive all anodes high and led_seg to 1111111.
REQ-030 All outputs SHALL derive from registered state; there is no combinational path from add, rst1 or rst2 to any output.

Reset
REQ-031 On rst high at a clk edge, cnt, prescaler, scan counter and edge registers SHALL clear.
REQ-032 Edge registers SHALL clear to 0, so an input held high through reset triggers one edge on the first cycle after release.
REQ-033 After reset the outputs SHALL be val* = 0, expired = 1, a1 = 0, a2..a4 = 1, led_seg = 1000000, then follow the zero-blink pattern.
REQ-034 rst asserted mid-countdown SHALL override any coin, preset or tick in the same cycle.

Verification
REQ-035 The bench SHALL check: rst for 10 cycles -> cnt 0, expired 1, display on for 50 cycles then blank for 50.
REQ-036 The bench SHALL check: add[0] pulse at cnt 0 -> val 0060, expired 0, blinking from the start; after 6000 cycles -> 0000, expired 1.
REQ-037 The bench SHALL check: add[0] and add[1] rising in the same cycle -> +180; add[2] held 500 cycles -> exactly +180.
REQ-038 The bench SHALL check: 35 add[3] pulses from 0 -> saturates at 9999 and remains 9999 until the next tick, then 9998.
REQ-039 The bench SHALL check: rst1 at cnt 290 -> 0015 next cycle with prescaler restarted; rst1 and rst2 together -> 0015; rst2 -> 0150 with even/odd blinking.
REQ-040 The bench SHALL check: a coin edge coincident with a tick at cnt 9990 and credit 60 -> 9999; at cnt 0 -> exactly 60.
